axis_register_responder: RTL and testbench

//   Responder end of the axi_stream address-request / data-response read protocol used by axis_data_mover.

---
 rtl/axis_register_responder_if.sv | 18 +
 rtl/axis_register_responder.sv | 130 +++++++++++++
 tb/tb_axis_register_responder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/axis_register_responder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_stream : valid/ready stream carrying a data word and a destination tag.
// Revision   : 1.0
// ---------------------------------------------------------------------------
interface axi_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [DEST_WIDTH-1:0] dest;

  modport master (output valid, output data, output dest, input ready);
  modport slave  (input valid, input data, input dest, output ready);
endinterface
`default_nettype wire

// File: rtl/axis_register_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axis_register_responder : register bank answering stream read requests
//                           with one response beat each, written via stream.
// Revision                : 1.0
// ---------------------------------------------------------------------------
module axis_register_responder #(
  parameter int                       DATA_WIDTH      = 32,
  parameter int                       ADDRESS_WIDTH   = 32,
  parameter int                       REGISTER_NUMBER = 4,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR       = '0,
  parameter logic [DATA_WIDTH-1:0]    UNMAPPED_VALUE  = DATA_WIDTH'(32'hDEADBEEF)
) (
  input  wire logic clock,
  input  wire logic reset,
  axi_stream.slave  request,
  axi_stream.master response,
  axi_stream.slave  write_in,
  output logic      read_error,
  output logic      write_error
);

  localparam int IDX_W = (REGISTER_NUMBER > 1) ? $clog2(REGISTER_NUMBER) : 1;
  localparam logic [ADDRESS_WIDTH:0] REG_COUNT = (ADDRESS_WIDTH + 1)'(REGISTER_NUMBER);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] RESPOND = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [DATA_WIDTH-1:0]   regs_q [REGISTER_NUMBER];
  logic [DATA_WIDTH-1:0]   regs_d [REGISTER_NUMBER];
  logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
  logic [ADDRESS_WIDTH-1:0] resp_dest_q, resp_dest_d;
  logic                    read_error_q, read_error_d;
  logic                    write_error_q, write_error_d;

  logic [ADDRESS_WIDTH-1:0] w_rd_off, w_wr_off;
  logic                     w_rd_mapped, w_wr_mapped;
  logic [IDX_W-1:0]         w_rd_idx, w_wr_idx;
  logic                     w_req_fire;
  logic                     unused_request_dest;

  // Offsets are taken modulo 2^ADDRESS_WIDTH; the lower-bound test rejects wrapped values.
  assign w_rd_off    = request.data - BASE_ADDR;
  assign w_wr_off    = write_in.dest - BASE_ADDR;
  assign w_rd_mapped = (request.data >= BASE_ADDR) && ({1'b0, w_rd_off} < REG_COUNT);
  assign w_wr_mapped = (write_in.dest >= BASE_ADDR) && ({1'b0, w_wr_off} < REG_COUNT);
  assign w_rd_idx    = w_rd_off[IDX_W-1:0];
  assign w_wr_idx    = w_wr_off[IDX_W-1:0];
  assign w_req_fire  = (state_q == IDLE) && request.valid;

  assign unused_request_dest = ^request.dest;

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      resp_data_q   <= '0;
      resp_dest_q   <= '0;
      read_error_q  <= 1'b0;
      write_error_q <= 1'b0;
      for (int i = 0; i < REGISTER_NUMBER; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      resp_data_q   <= resp_data_d;
      resp_dest_q   <= resp_dest_d;
      read_error_q  <= read_error_d;
      write_error_q <= write_error_d;
      for (int i = 0; i < REGISTER_NUMBER; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (request.valid)  state_d = RESPOND;
      RESPOND: if (response.ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bank update and write-error detection
  always_comb begin
    regs_d        = regs_q;
    write_error_d = 1'b0;
    if (write_in.valid) begin
      if (w_wr_mapped) begin
        regs_d[w_wr_idx] = write_in.data;
      end else begin
        write_error_d = 1'b1;
      end
    end
  end

  // Response capture: a same-cycle write to the read target wins over the stored value
  always_comb begin
    resp_data_d  = resp_data_q;
    resp_dest_d  = resp_dest_q;
    read_error_d = 1'b0;
    if (w_req_fire) begin
      resp_dest_d = request.data;
      if (!w_rd_mapped) begin
        resp_data_d  = UNMAPPED_VALUE;
        read_error_d = 1'b1;
      end else if (write_in.valid && w_wr_mapped && (w_wr_idx == w_rd_idx)) begin
        resp_data_d = write_in.data;
      end else begin
        resp_data_d = regs_q[w_rd_idx];
      end
    end
  end

  // Outputs
  always_comb begin
    request.ready  = (state_q == IDLE);
    response.valid = (state_q == RESPOND);
    response.data  = resp_data_q;
    response.dest  = resp_dest_q;
    write_in.ready = 1'b1;
    read_error     = read_error_q;
    write_error    = write_error_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_register_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_axis_register_responder : directed and random stimulus against a
//                              transaction-level model of the register bank.
// Revision                   : 1.0
// ---------------------------------------------------------------------------
module tb_axis_register_responder;

  localparam int          DW  = 32;
  localparam int          AW  = 32;
  localparam int          RN  = 4;
  localparam logic [31:0] UNM = 32'hDEADBEEF;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  axi_stream #(.DATA_WIDTH(AW), .DEST_WIDTH(AW)) request ();
  axi_stream #(.DATA_WIDTH(DW), .DEST_WIDTH(AW)) response ();
  axi_stream #(.DATA_WIDTH(DW), .DEST_WIDTH(AW)) write_in ();
  logic read_error, write_error;

  axis_register_responder #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .REGISTER_NUMBER(RN),
    .BASE_ADDR('0), .UNMAPPED_VALUE(UNM)
  ) dut (
    .clock(clock), .reset(reset),
    .request(request), .response(response), .write_in(write_in),
    .read_error(read_error), .write_error(write_error)
  );

  // Model: bank contents plus the single outstanding response, if any
  logic [DW-1:0] bank [RN];
  bit            m_busy;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_dest;
  bit            m_rerr, m_werr;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < RN; i++) bank[i] = '0;
    m_busy = 0; m_data = '0; m_dest = '0; m_rerr = 0; m_werr = 0;
  endtask

  // One clock edge of protocol behaviour, evaluated on the inputs present at that edge
  task automatic model_step();
    logic [AW-1:0] a;
    bit take_req, give_resp;
    take_req  = !m_busy && request.valid;
    give_resp = m_busy && response.ready;
    m_rerr = 0;
    m_werr = 0;
    if (take_req) begin
      a = request.data;
      m_dest = a;
      if (a >= RN) begin
        m_data = UNM;
        m_rerr = 1;
      end else if (write_in.valid && write_in.dest == a) begin
        m_data = write_in.data;
      end else begin
        m_data = bank[a];
      end
      m_busy = 1;
    end else if (give_resp) begin
      m_busy = 0;
    end
    if (write_in.valid) begin
      if (write_in.dest < RN) bank[write_in.dest] = write_in.data;
      else m_werr = 1;
    end
  endtask

  task automatic compare_all();
    check("req_ready", request.ready, m_busy ? 0 : 1);
    check("resp_valid", response.valid, m_busy ? 1 : 0);
    if (m_busy) begin
      check("resp_data", response.data, m_data);
      check("resp_dest", response.dest, m_dest);
    end
    check("read_error", read_error, m_rerr);
    check("write_error", write_error, m_werr);
    check("wr_ready", write_in.ready, 1);
  endtask

  // Called at a negedge: drive inputs, let one edge pass, compare at the next negedge
  task automatic cycle(input bit rv, input logic [AW-1:0] ra, input bit wv,
                       input logic [DW-1:0] wd, input logic [AW-1:0] wa, input bit rr);
    request.valid  = rv;
    request.data   = ra;
    write_in.valid = wv;
    write_in.data  = wd;
    write_in.dest  = wa;
    response.ready = rr;
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_all();
  endtask

  initial begin
    request.valid  = 0; request.data = '0; request.dest = '0;
    write_in.valid = 0; write_in.data = '0; write_in.dest = '0;
    response.ready = 0;
    model_reset();
    repeat (3) @(negedge clock);
    check("rst_req_ready", request.ready, 1);
    check("rst_resp_valid", response.valid, 0);
    check("rst_resp_data", response.data, 0);
    check("rst_resp_dest", response.dest, 0);
    check("rst_rerr", read_error, 0);
    check("rst_werr", write_error, 0);
    reset = 1;

    // Reads of a fresh bank
    for (int a = 0; a < RN; a++) begin
      cycle(1, a, 0, 0, 0, 1);
      check("t1_valid", response.valid, 1);
      check("t1_data", response.data, 0);
      check("t1_dest", response.dest, a);
      cycle(0, 0, 0, 0, 0, 1);
    end

    // Fill then read back register 2
    for (int a = 0; a < RN; a++) cycle(0, 0, 1, 32'h11 * (a + 1), a, 1);
    cycle(1, 2, 0, 0, 0, 1);
    check("t2_data", response.data, 32'h33);
    check("t2_dest", response.dest, 2);
    check("t2_rerr", read_error, 0);
    cycle(0, 0, 0, 0, 0, 1);

    // Unmapped read and write
    cycle(1, 7, 0, 0, 0, 1);
    check("t3_data", response.data, 32'hDEADBEEF);
    check("t3_dest", response.dest, 7);
    check("t3_rerr", read_error, 1);
    cycle(0, 0, 0, 0, 0, 1);
    check("t3_rerr_pulse", read_error, 0);
    cycle(0, 0, 1, 32'h99, 9, 1);
    check("t3_werr", write_error, 1);
    cycle(0, 0, 0, 0, 0, 1);
    check("t3_werr_pulse", write_error, 0);

    // Same-cycle write and read of register 1
    cycle(1, 1, 1, 32'hAB, 1, 1);
    check("t4_data", response.data, 32'hAB);
    cycle(0, 0, 0, 0, 0, 1);

    // Back-pressure with a write to the register being returned
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 3, 1, 32'h55, 0, 0);
      check("t5_valid", response.valid, 1);
      check("t5_data", response.data, 32'h11);
      check("t5_ready", request.ready, 0);
    end
    cycle(0, 0, 0, 0, 0, 1);
    check("t5_ready_back", request.ready, 1);
    cycle(1, 0, 0, 0, 0, 1);
    check("t5_newdata", response.data, 32'h55);
    cycle(0, 0, 0, 0, 0, 1);

    // Asynchronous reset while a response is pending
    cycle(1, 1, 0, 0, 0, 0);
    #2 reset = 0;
    #1;
    check("t6_valid_async", response.valid, 0);
    check("t6_ready_async", request.ready, 1);
    model_reset();
    request.valid = 0; response.ready = 1;
    @(negedge clock);
    reset = 1;
    cycle(0, 0, 0, 0, 0, 1);
    check("t6_no_stale", response.valid, 0);
    cycle(1, 1, 0, 0, 0, 1);
    check("t6_cleared", response.data, 0);
    cycle(0, 0, 0, 0, 0, 1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic [AW-1:0] ra, wa;
      ra = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 9));
      wa = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 6));
      cycle($urandom_range(0, 1) == 1, ra, $urandom_range(0, 1) == 1, $urandom, wa,
            $urandom_range(0, 9) < 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
